midi_rx_parser: RTL and testbench

//  Serial MIDI front end that drives the midi_player note interface.

---
 rtl/midi_rx_parser_pkg.sv | 23 ++
 rtl/midi_uart_rx.sv | 87 ++++++++
 rtl/midi_rx_parser.sv | 96 +++++++++
 tb/tb_midi_rx_parser.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_rx_parser_pkg.sv
// Shared MIDI constants and state encodings for the serial receiver and
// the Note On/Off parser.
package midi_rx_parser_pkg;

   localparam logic [3:0] MIDI_NOTE_OFF     = 4'h8;
   localparam logic [3:0] MIDI_NOTE_ON      = 4'h9;
   localparam logic [7:0] MIDI_REALTIME_MIN = 8'hF8;
   localparam logic [7:0] MIDI_SYSCOM_MIN   = 8'hF0;

   typedef enum logic [1:0] {
      UART_IDLE  = 2'd0,
      UART_START = 2'd1,
      UART_DATA  = 2'd2,
      UART_STOP  = 2'd3
   } uart_state_t;

   typedef enum logic [1:0] {
      WAIT_STATUS = 2'd0,
      WAIT_NOTE   = 2'd1,
      WAIT_VEL    = 2'd2
   } parse_state_t;

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver for the MIDI input: two-flop synchroniser, bit timer and
// framing FSM producing one-cycle byte_valid / frame_error pulses.
module midi_uart_rx
   import midi_rx_parser_pkg::*;
#(
   parameter int CLKS_PER_BIT = 800
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       midi_rx,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_error
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

   uart_state_t      state;
   logic [1:0]       sync_q;
   logic             rx_prev;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic             rx_s;

   assign rx_s = sync_q[1];

   // Edge detection (not level) so a line left low after a bad stop bit
   // cannot start a phantom frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 2'b11;
         rx_prev     <= 1'b1;
         state       <= UART_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], midi_rx};
         rx_prev     <= rx_s;
         byte_valid  <= 1'b0;
         frame_error <= 1'b0;
         case (state)
            UART_IDLE: begin
               cnt <= '0;
               if (rx_prev && !rx_s) state <= UART_START;
            end
            UART_START: begin
               if (cnt == HALF_END) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  state   <= rx_s ? UART_IDLE : UART_DATA;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UART_DATA: begin
               if (cnt == BIT_END) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 3'd7) state <= UART_STOP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            UART_STOP: begin
               if (cnt == BIT_END) begin
                  cnt         <= '0;
                  byte_valid  <= rx_s;
                  frame_error <= !rx_s;
                  state       <= UART_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= UART_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == UART_DATA && cnt == BIT_END) rx_byte <= {rx_s, rx_byte[7:1]};
   end

endmodule

// File: rtl/midi_rx_parser.sv
// MIDI input front end: UART receive plus Note On/Off parsing with running
// status, producing a monophonic last-note-priority gate for midi_player.
module midi_rx_parser
   import midi_rx_parser_pkg::*;
#(
   parameter int CLK_FREQ       = 25_000_000,
   parameter int BAUD           = 31250,
   parameter int CHANNEL        = 0,
   parameter bit OMNI           = 1'b0,
   parameter int AMPLITUDE_BITS = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      midi_rx,
   output logic [7:0]                midi_data,
   output logic                      midi_valid,
   output logic [AMPLITUDE_BITS-1:0] amplitude,
   output logic                      frame_error
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   logic [7:0]   rx_byte;
   logic         byte_valid;
   parse_state_t pstate;
   logic         cmd_on;
   logic [6:0]   note_r;
   logic         chan_ok;
   logic         is_note_cmd;

   midi_uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart (
      .clk        (clk),
      .rst_n      (rst_n),
      .midi_rx    (midi_rx),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_error(frame_error)
   );

   // 7-bit velocity left-aligned, vacated low bits replicate v[6] so 0x7F
   // reaches full scale.
   function automatic logic [AMPLITUDE_BITS-1:0] vel_to_amp(input logic [6:0] v);
      logic [AMPLITUDE_BITS-1:0] a;
      a = {AMPLITUDE_BITS{v[6]}};
      a[AMPLITUDE_BITS-1 -: 7] = v;
      return a;
   endfunction

   assign chan_ok     = OMNI || (rx_byte[3:0] == 4'(CHANNEL));
   assign is_note_cmd = (rx_byte[7:4] == MIDI_NOTE_ON) || (rx_byte[7:4] == MIDI_NOTE_OFF);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pstate     <= WAIT_STATUS;
         cmd_on     <= 1'b0;
         note_r     <= '0;
         midi_data  <= '0;
         midi_valid <= 1'b0;
         amplitude  <= '0;
      end else if (byte_valid) begin
         if (rx_byte >= MIDI_REALTIME_MIN) begin
            pstate <= pstate;
         end else if (rx_byte >= MIDI_SYSCOM_MIN) begin
            pstate <= WAIT_STATUS;
         end else if (rx_byte[7]) begin
            if (is_note_cmd && chan_ok) begin
               cmd_on <= (rx_byte[7:4] == MIDI_NOTE_ON);
               pstate <= WAIT_NOTE;
            end else begin
               pstate <= WAIT_STATUS;
            end
         end else begin
            case (pstate)
               WAIT_NOTE: begin
                  note_r <= rx_byte[6:0];
                  pstate <= WAIT_VEL;
               end
               WAIT_VEL: begin
                  pstate <= WAIT_NOTE;
                  if (cmd_on && rx_byte[6:0] != 7'd0) begin
                     midi_data  <= {1'b0, note_r};
                     amplitude  <= vel_to_amp(rx_byte[6:0]);
                     midi_valid <= 1'b1;
                  end else if (midi_valid && {1'b0, note_r} == midi_data) begin
                     midi_valid <= 1'b0;
                  end
               end
               default: pstate <= WAIT_STATUS;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_midi_rx_parser.sv
// Directed bench for midi_rx_parser at 100 clocks per MIDI bit.
module tb_midi_rx_parser;

   localparam int CPB = 100;

   logic       clk;
   logic       rst_n;
   logic       midi_rx;
   logic [7:0] midi_data;
   logic       midi_valid;
   logic [7:0] amplitude;
   logic       frame_error;

   int pass_cnt = 0;
   int total    = 0;
   int fe_count = 0;

   midi_rx_parser #(
      .CLK_FREQ      (3_125_000),
      .BAUD          (31250),
      .CHANNEL       (0),
      .OMNI          (1'b0),
      .AMPLITUDE_BITS(8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .midi_rx    (midi_rx),
      .midi_data  (midi_data),
      .midi_valid (midi_valid),
      .amplitude  (amplitude),
      .frame_error(frame_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (frame_error) fe_count++;

   task automatic send_bit(input logic b);
      midi_rx = b;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
      if (!stop) send_bit(1'b1);
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      midi_rx = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (midi_data !== 8'h00) $display("FAIL reset_data got %h want 00", midi_data);
      else pass_cnt++;
      total++;
      if (midi_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", midi_valid);
      else pass_cnt++;
      total++;
      if (amplitude !== 8'h00) $display("FAIL reset_amp got %h want 00", amplitude);
      else pass_cnt++;
      total++;
      if (fe_count !== 0) $display("FAIL reset_fe got %0d want 0", fe_count);
      else pass_cnt++;
   endtask

   task automatic test_note_on;
      send_byte(8'h90, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h64, 1'b1);
      total++;
      if (midi_data !== 8'h3C) $display("FAIL s1_data got %h want 3c", midi_data);
      else pass_cnt++;
      total++;
      if (midi_valid !== 1'b1) $display("FAIL s1_valid got %b want 1", midi_valid);
      else pass_cnt++;
      total++;
      if (amplitude !== 8'hC9) $display("FAIL s1_amp got %h want c9", amplitude);
      else pass_cnt++;
   endtask

   task automatic test_running_status;
      send_byte(8'h40, 1'b1);
      send_byte(8'h50, 1'b1);
      total++;
      if ({midi_valid, midi_data, amplitude} !== {1'b1, 8'h40, 8'hA1})
         $display("FAIL s2_run got %b/%h/%h want 1/40/a1", midi_valid, midi_data, amplitude);
      else pass_cnt++;
      send_byte(8'h80, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h00, 1'b1);
      total++;
      if ({midi_valid, midi_data, amplitude} !== {1'b1, 8'h40, 8'hA1})
         $display("FAIL s2_off_other got %b/%h/%h want 1/40/a1", midi_valid, midi_data, amplitude);
      else pass_cnt++;
      send_byte(8'h80, 1'b1);
      send_byte(8'h40, 1'b1);
      send_byte(8'h00, 1'b1);
      total++;
      if ({midi_valid, midi_data, amplitude} !== {1'b0, 8'h40, 8'hA1})
         $display("FAIL s2_off_cur got %b/%h/%h want 0/40/a1", midi_valid, midi_data, amplitude);
      else pass_cnt++;
   endtask

   task automatic test_realtime;
      send_byte(8'h90, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'hF8, 1'b1);
      send_byte(8'h64, 1'b1);
      total++;
      if ({midi_valid, midi_data, amplitude} !== {1'b1, 8'h3C, 8'hC9})
         $display("FAIL s3_rt got %b/%h/%h want 1/3c/c9", midi_valid, midi_data, amplitude);
      else pass_cnt++;
      send_byte(8'h90, 1'b1);
      send_byte(8'h45, 1'b1);
      send_byte(8'h64, 1'b1);
      total++;
      if ({midi_valid, midi_data} !== {1'b1, 8'h45})
         $display("FAIL s3_on45 got %b/%h want 1/45", midi_valid, midi_data);
      else pass_cnt++;
      send_byte(8'h90, 1'b1);
      send_byte(8'h45, 1'b1);
      send_byte(8'h00, 1'b1);
      total++;
      if ({midi_valid, midi_data, amplitude} !== {1'b0, 8'h45, 8'hC9})
         $display("FAIL s3_vel0 got %b/%h/%h want 0/45/c9", midi_valid, midi_data, amplitude);
      else pass_cnt++;
   endtask

   task automatic test_channel_filter;
      send_byte(8'h91, 1'b1);
      send_byte(8'h3C, 1'b1);
      send_byte(8'h64, 1'b1);
      total++;
      if ({midi_valid, midi_data} !== {1'b0, 8'h45})
         $display("FAIL s4_chan got %b/%h want 0/45", midi_valid, midi_data);
      else pass_cnt++;
      send_byte(8'hB0, 1'b1);
      send_byte(8'h07, 1'b1);
      send_byte(8'h7F, 1'b1);
      total++;
      if ({midi_valid, midi_data} !== {1'b0, 8'h45})
         $display("FAIL s4_cc got %b/%h want 0/45", midi_valid, midi_data);
      else pass_cnt++;
      send_byte(8'h3C, 1'b1);
      send_byte(8'h64, 1'b1);
      total++;
      if ({midi_valid, midi_data} !== {1'b0, 8'h45})
         $display("FAIL s4_rs_cleared got %b/%h want 0/45", midi_valid, midi_data);
      else pass_cnt++;
   endtask

   task automatic test_frame_error;
      int fe0;
      send_byte(8'h90, 1'b1);
      fe0 = fe_count;
      send_byte(8'h3C, 1'b0);
      total++;
      if (fe_count - fe0 !== 1) $display("FAIL s5_fe_pulse got %0d want 1", fe_count - fe0);
      else pass_cnt++;
      send_byte(8'h3D, 1'b1);
      send_byte(8'h64, 1'b1);
      total++;
      if ({midi_valid, midi_data, amplitude} !== {1'b1, 8'h3D, 8'hC9})
         $display("FAIL s5_after_fe got %b/%h/%h want 1/3d/c9", midi_valid, midi_data, amplitude);
      else pass_cnt++;
   endtask

   task automatic test_glitch;
      int fe0;
      fe0 = fe_count;
      send_byte(8'h50, 1'b1);
      midi_rx = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      midi_rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      total++;
      if (fe_count - fe0 !== 0) $display("FAIL s5_glitch_fe got %0d want 0", fe_count - fe0);
      else pass_cnt++;
      send_byte(8'h60, 1'b1);
      total++;
      if ({midi_valid, midi_data, amplitude} !== {1'b1, 8'h50, 8'hC1})
         $display("FAIL s5_glitch got %b/%h/%h want 1/50/c1", midi_valid, midi_data, amplitude);
      else pass_cnt++;
   endtask

   task automatic test_midreset;
      send_byte(8'h90, 1'b1);
      send_byte(8'h20, 1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      @(negedge clk);
      rst_n   = 1'b0;
      midi_rx = 1'b1;
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      total++;
      if ({midi_valid, midi_data, amplitude} !== {1'b0, 8'h00, 8'h00})
         $display("FAIL s6_reset got %b/%h/%h want 0/00/00", midi_valid, midi_data, amplitude);
      else pass_cnt++;
      send_byte(8'h90, 1'b1);
      send_byte(8'h30, 1'b1);
      send_byte(8'h7F, 1'b1);
      total++;
      if (midi_data !== 8'h30) $display("FAIL s6_data got %h want 30", midi_data);
      else pass_cnt++;
      total++;
      if (midi_valid !== 1'b1) $display("FAIL s6_valid got %b want 1", midi_valid);
      else pass_cnt++;
      total++;
      if (amplitude !== 8'hFF) $display("FAIL s6_amp got %h want ff", amplitude);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_note_on();
      test_running_status();
      test_realtime();
      test_channel_filter();
      test_frame_error();
      test_glitch();
      test_midreset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
